// File: rtl/obi_dmem_responder_pkg.sv
// Shared widths, grant FSM encodings and byte-enable helpers for the OBI
// data-memory responder.
package obi_dmem_responder_pkg;

  localparam int OBI_AW  = 64;
  localparam int OBI_DW  = 64;
  localparam int OBI_BEW = 8;

  typedef enum logic [1:0] {
    OBI_RSP_IDLE  = 2'd0,
    OBI_RSP_WAIT  = 2'd1,
    OBI_RSP_GRANT = 2'd2
  } obi_rsp_state_e;

  // Replace only the byte lanes selected by be, keep the rest of old_word.
  function automatic logic [OBI_DW-1:0] be_merge(
    input logic [OBI_DW-1:0]  old_word,
    input logic [OBI_DW-1:0]  new_word,
    input logic [OBI_BEW-1:0] be
  );
    logic [OBI_DW-1:0] mask;
    mask = '0;
    for (int n = 0; n < OBI_BEW; n++) begin
      mask[8*n +: 8] = {8{be[n]}};
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// Fixed-depth response shift register: one slot per cycle of response latency.
// Only the valid bits are reset; err/data are masked by valid at the output.
module obi_resp_pipe #(
  parameter int DEPTH = 1,
  parameter int DW    = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_err,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic          o_err,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_err;
  logic [DW-1:0]    r_data [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_push;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_err[0]  <= i_err;
    r_data[0] <= i_data;
    for (int i = 1; i < DEPTH; i++) begin
      r_err[i]  <= r_err[i-1];
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_err   = r_valid[DEPTH-1] & r_err[DEPTH-1];
  assign o_data  = r_valid[DEPTH-1] ? r_data[DEPTH-1] : '0;

endmodule

// File: rtl/obi_dmem_responder.sv
// OBI device-side data memory: programmable grant wait states, byte-enabled
// 64-bit storage, fixed-latency responses and a sticky host protocol checker.
module obi_dmem_responder
  import obi_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int RESP_LATENCY = 1,
  parameter int GNT_WAIT     = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [OBI_AW-1:0]  addr_i,
  input  logic               we_i,
  input  logic [OBI_BEW-1:0] be_i,
  input  logic [OBI_DW-1:0]  wdata_i,
  output logic               rvalid_o,
  output logic [OBI_DW-1:0]  rdata_o,
  output logic               err_o,
  output logic               proto_err_o
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LOAD = 3'(GNT_WAIT - 1);

  logic [OBI_DW-1:0]  r_mem [DEPTH_WORDS];
  obi_rsp_state_e     r_state;
  obi_rsp_state_e     w_state_nxt;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_nxt;

  logic               r_pend;
  logic [OBI_AW-1:0]  r_addr;
  logic               r_we;
  logic [OBI_BEW-1:0] r_be;
  logic [OBI_DW-1:0]  r_wdata;
  logic               r_proto_err;

  logic [IDX_W-1:0]   w_idx;
  logic               w_oor;
  logic               w_hs;
  logic               w_chg;
  logic               w_viol;
  logic [OBI_DW-1:0]  w_rd_word;
  logic [OBI_DW-1:0]  w_rsp_data;

  assign w_idx = addr_i[IDX_W+2:3];
  assign w_oor = |addr_i[OBI_AW-1:IDX_W+3];
  assign w_hs  = req_i & gnt_o;

  // With no wait states the grant follows the request directly.
  assign gnt_o = (GNT_WAIT == 0) ? (req_i & ~rst_i) : (r_state == OBI_RSP_GRANT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= OBI_RSP_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The IDLE cycle counts as the first wait cycle, so WAIT lasts GNT_WAIT-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      OBI_RSP_IDLE: begin
        if (req_i && (GNT_WAIT > 0)) begin
          w_cnt_nxt   = WAIT_LOAD;
          w_state_nxt = (GNT_WAIT == 1) ? OBI_RSP_GRANT : OBI_RSP_WAIT;
        end else begin
          w_cnt_nxt = 3'd0;
        end
      end
      OBI_RSP_WAIT: begin
        if (!req_i) begin
          w_state_nxt = OBI_RSP_IDLE;
          w_cnt_nxt   = 3'd0;
        end else if (r_cnt <= 3'd1) begin
          w_state_nxt = OBI_RSP_GRANT;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      OBI_RSP_GRANT: begin
        w_state_nxt = OBI_RSP_IDLE;
      end
      default: begin
        w_state_nxt = OBI_RSP_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && we_i && !w_oor) begin
      r_mem[w_idx] <= be_merge(r_mem[w_idx], wdata_i, be_i);
    end
  end

  // Reads see the array before this edge's update; only one handshake per cycle.
  assign w_rd_word  = r_mem[w_idx];
  assign w_rsp_data = (we_i || w_oor) ? '0 : w_rd_word;

  obi_resp_pipe #(
    .DEPTH (RESP_LATENCY),
    .DW    (OBI_DW)
  ) u_resp_pipe (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_hs),
    .i_err   (w_oor),
    .i_data  (w_rsp_data),
    .o_valid (rvalid_o),
    .o_err   (err_o),
    .o_data  (rdata_o)
  );

  assign w_chg  = (addr_i != r_addr) | (we_i != r_we) | (be_i != r_be) | (wdata_i != r_wdata);
  assign w_viol = r_pend & (~req_i | (~gnt_o & w_chg));

  // r_pend marks a request left ungranted last cycle, the only case that is checked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend      <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_pend <= req_i & ~gnt_o;
      if (req_i) begin
        r_addr  <= addr_i;
        r_we    <= we_i;
        r_be    <= be_i;
        r_wdata <= wdata_i;
      end
      if (w_viol) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_obi_dmem_responder.sv
// Three responders (GNT_WAIT/RESP_LATENCY = 0/1, 3/2, 2/3) checked against a
// transaction-level model: word array, grant-wait count and response due cycle.
module tb_obi_dmem_responder;

  logic        clk;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [63:0] addr  [3];
  logic [63:0] wdata [3];
  logic [7:0]  be    [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic        err   [3];
  logic        perr  [3];
  logic [63:0] rdata [3];

  typedef struct {
    int          cyc;
    logic        e;
    logic [63:0] d;
  } exp_t;

  exp_t        eq [3][64];
  int          hd [3];
  int          tl [3];
  logic [63:0] mdl [3][16];
  logic [63:0] last_rd [3];
  int          cyc;
  int          n_cmp;
  int          n_bad;

  obi_dmem_responder #(.DEPTH_WORDS(1024), .RESP_LATENCY(1), .GNT_WAIT(0)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .proto_err_o(perr[0]));

  obi_dmem_responder #(.DEPTH_WORDS(1024), .RESP_LATENCY(2), .GNT_WAIT(3)) u_b (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .proto_err_o(perr[1]));

  obi_dmem_responder #(.DEPTH_WORDS(1024), .RESP_LATENCY(3), .GNT_WAIT(2)) u_c (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]), .proto_err_o(perr[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic int gw_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int rl_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL dut%0d %s: observed %h expected %h", k, tag, obs, expv);
    end
  endtask

  // Response monitor: reset discards everything in flight; otherwise rvalid must
  // appear exactly at each due cycle and nowhere else.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst[k]) begin
          chk(k, "reset_ctrl_outs", 64'({gnt[k], rvalid[k], err[k], perr[k]}), 64'd0);
          chk(k, "reset_rdata", rdata[k], 64'd0);
          hd[k] = tl[k];
        end else if (hd[k] != tl[k] && eq[k][hd[k] % 64].cyc == cyc) begin
          chk(k, "rvalid_due", 64'(rvalid[k]), 64'd1);
          chk(k, "rsp_err", 64'(err[k]), 64'(eq[k][hd[k] % 64].e));
          chk(k, "rsp_rdata", rdata[k], eq[k][hd[k] % 64].d);
          last_rd[k] = rdata[k];
          hd[k]++;
        end else begin
          chk(k, "rvalid_idle", 64'(rvalid[k]), 64'd0);
        end
      end
    end
  end

  task automatic start_txn(input int k, input logic w, input logic [63:0] a,
                           input logic [7:0] b, input logic [63:0] d);
    we[k]    = w;
    addr[k]  = a;
    be[k]    = b;
    wdata[k] = d;
    req[k]   = 1'b1;
  endtask

  // Wait for the grant, then apply the transaction to the word-array model.
  task automatic wait_grant(input int k, input bit check_waits);
    int          waits;
    bit          got;
    logic        e_err;
    logic [63:0] e_data;
    logic [63:0] m;
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) got = 1'b1;
      else waits++;
    end
    chk(k, "grant_seen", 64'(got), 64'd1);
    if (got && check_waits) chk(k, "grant_wait_cycles", 64'(waits), 64'(gw_of(k)));
    if (got) begin
      e_err  = |addr[k][63:13];
      e_data = 64'd0;
      if (!e_err && we[k]) begin
        for (int n = 0; n < 8; n++) m[8*n +: 8] = be[k][n] ? 8'hFF : 8'h00;
        mdl[k][addr[k][6:3]] = (mdl[k][addr[k][6:3]] & ~m) | (wdata[k] & m);
      end else if (!e_err) begin
        e_data = mdl[k][addr[k][6:3]];
      end
      eq[k][tl[k] % 64].cyc = cyc + rl_of(k);
      eq[k][tl[k] % 64].e   = e_err;
      eq[k][tl[k] % 64].d   = e_data;
      tl[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int k, input logic w, input logic [63:0] a,
                        input logic [7:0] b, input logic [63:0] d);
    start_txn(k, w, a, b, d);
    wait_grant(k, 1'b1);
  endtask

  task automatic idle(input int k, input int n);
    req[k] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_txn(input int k);
    logic [63:0] a;
    logic [7:0]  b;
    a = {57'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'b00};
    if ($urandom_range(0, 7) == 0) a[13 + $urandom_range(0, 50)] = 1'b1;
    b = 8'($urandom);
    if ($urandom_range(0, 9) == 0) b = 8'h00;
    do_txn(k, 1'($urandom_range(0, 1)), a, b, {$urandom, $urandom});
    if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(0, 2));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
      addr[k] = 64'd0; wdata[k] = 64'd0; be[k] = 8'h00;
      hd[k] = 0; tl[k] = 0; last_rd[k] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) do_txn(k, 1'b1, 64'(i) << 3, 8'hFF, {$urandom, $urandom});
      idle(k, 2);
    end

    // Write then read the same word on back-to-back cycles.
    do_txn(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788);
    do_txn(0, 1'b0, 64'h10, 8'hFF, 64'd0);
    idle(0, 2);
    chk(0, "raw_readback", last_rd[0], 64'h1122334455667788);

    // Upper-lane merge into a fully written word.
    do_txn(0, 1'b1, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    do_txn(0, 1'b1, 64'h4, 8'hF0, 64'hAAAAAAAA_AAAAAAAA);
    do_txn(0, 1'b0, 64'h0, 8'hFF, 64'd0);
    idle(0, 2);
    chk(0, "byte_merge", last_rd[0], 64'hAAAAAAAA_FFFFFFFF);

    // Out-of-range read and write, then index 0 must be untouched.
    do_txn(0, 1'b0, 64'h2000, 8'hFF, 64'd0);
    do_txn(0, 1'b1, 64'h2000, 8'hFF, 64'h0123456789ABCDEF);
    do_txn(0, 1'b0, 64'h0, 8'hFF, 64'd0);
    idle(0, 2);
    chk(0, "oor_no_alias", last_rd[0], 64'hAAAAAAAA_FFFFFFFF);

    for (int i = 0; i < 80; i++) rand_txn(0);
    idle(0, 3);

    // Held request, two back-to-back transactions with three wait cycles each.
    do_txn(1, 1'b1, 64'h18, 8'h0F, 64'h5555_6666_7777_8888);
    do_txn(1, 1'b0, 64'h18, 8'hFF, 64'd0);
    idle(1, 4);
    for (int i = 0; i < 30; i++) rand_txn(1);
    idle(1, 4);

    for (int i = 0; i < 20; i++) rand_txn(2);
    idle(2, 4);

    // Reset one cycle after a granted write: its response must never appear.
    do_txn(2, 1'b1, 64'h28, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    req[2] = 1'b0;
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    idle(2, 6);
    do_txn(2, 1'b0, 64'h28, 8'hFF, 64'd0);
    idle(2, 4);
    chk(2, "write_survives_reset", last_rd[2], 64'hDEAD_BEEF_0BAD_F00D);

    // Address changes while waiting for the grant.
    chk(2, "proto_clean", 64'(perr[2]), 64'd0);
    start_txn(2, 1'b0, 64'h08, 8'hFF, 64'd0);
    @(posedge clk);
    #1;
    addr[2] = 64'h18;
    wait_grant(2, 1'b0);
    chk(2, "proto_set", 64'(perr[2]), 64'd1);
    idle(2, 5);
    chk(2, "proto_sticky", 64'(perr[2]), 64'd1);
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    chk(2, "proto_cleared", 64'(perr[2]), 64'd0);
    idle(2, 4);

    chk(0, "proto_none", 64'(perr[0]), 64'd0);
    chk(1, "proto_none", 64'(perr[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
